// File: rtl/conv_window_feeder_pkg.sv
// Shared types and constants for the 3x3 convolution window feeder.
package conv_pkg;

  localparam int PIX_W  = 8;              // pixel / weight width
  localparam int K      = 3;              // kernel is K x K
  localparam int ROW_W  = PIX_W * K;      // one window row / kernel row
  localparam int KERN_W = PIX_W * K * K;  // flattened kernel

  // ACCEPT takes pixels; EMITn presents window row n to the MAC.
  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    EMIT0  = 2'd1,
    EMIT1  = 2'd2,
    EMIT2  = 2'd3
  } feed_state_t;

  typedef logic [ROW_W-1:0] win_row_t;

  // Bit offset of kernel element k[i][j] inside the flattened kernel word.
  function automatic int unsigned k_byte_idx(input int unsigned i, input int unsigned j);
    return PIX_W * (K * i + j);
  endfunction

endpackage

// File: rtl/conv_window_feeder_if.sv
// Pixel-stream and MAC data/weight handshake bundle of the window feeder.
interface conv_window_feeder_if;
  import conv_pkg::*;

  // Pixel source -> feeder
  logic             pix_valid;
  logic             pix_ready;
  logic [PIX_W-1:0] pix_data;

  // Feeder -> MAC
  logic             mac_valid;
  logic             mac_ready;
  logic [ROW_W-1:0] data;
  logic [ROW_W-1:0] weight;
  logic             mac_last;
  logic             frame_last;

  // Feeder side: consumes pixels, produces MAC beats.
  modport slave (
    input  pix_valid, pix_data, mac_ready,
    output pix_ready, mac_valid, data, weight, mac_last, frame_last
  );

  // Environment side: pixel source and MAC.
  modport master (
    output pix_valid, pix_data, mac_ready,
    input  pix_ready, mac_valid, data, weight, mac_last, frame_last
  );

endinterface

// File: rtl/conv_window_feeder_line_buffer.sv
// Two-row line buffer: one column address, returns the two previous rows at
// that column and pushes a new pixel down the column on a write strobe.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int COL_W = $clog2(IMG_W)
) (
  input  logic             clk,
  input  logic [COL_W-1:0] i_col,
  input  logic             i_wr,
  input  logic [PIX_W-1:0] i_pix,
  output logic [PIX_W-1:0] o_lb1,   // two rows above the incoming pixel
  output logic [PIX_W-1:0] o_lb0    // one row above the incoming pixel
);

  logic [PIX_W-1:0] r_lb1 [IMG_W];
  logic [PIX_W-1:0] r_lb0 [IMG_W];

  assign o_lb1 = r_lb1[i_col];
  assign o_lb0 = r_lb0[i_col];

  // Shift the addressed column down by one row on every accepted pixel.
  // NOTE: storage arrays carry no reset so they map to plain RAM/regfile;
  // stale contents are never observed because windows need row >= 2.
  // NOTE: non-blocking assignments so both rows read the pre-edge values.
  always_ff @(posedge clk) begin
    if (i_wr) begin
      r_lb1[i_col] <= r_lb0[i_col];
      r_lb0[i_col] <= i_pix;
    end
  end

endmodule

// File: rtl/conv_window_feeder.sv
// Raster pixel stream -> 3x3 window -> three data/weight row-beats per window
// for the convolution MAC. Stalls the pixel source while a window is emitted.
module conv_window_feeder
  import conv_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              w_load,
  input  logic [KERN_W-1:0] w_kernel,
  conv_window_feeder_if.slave bus
);

  localparam int COL_W  = $clog2(IMG_W);
  localparam int ROW_CW = $clog2(IMG_H);

  feed_state_t       r_st;
  feed_state_t       w_st_nxt;

  logic [COL_W-1:0]  r_col;
  logic [ROW_CW-1:0] r_row;
  win_row_t          r_win [K];     // [0]=top, [1]=middle, [2]=bottom
  logic [KERN_W-1:0] r_kernel;
  logic              r_frame_end;

  logic              w_pix_hs;
  logic              w_col_last;
  logic              w_row_last;
  logic              w_win_done;
  logic [PIX_W-1:0]  w_lb1;
  logic [PIX_W-1:0]  w_lb0;

  assign w_pix_hs   = bus.pix_valid && (r_st == ACCEPT);
  assign w_col_last = (r_col == COL_W'(IMG_W - 1));
  assign w_row_last = (r_row == ROW_CW'(IMG_H - 1));
  // Columns 0/1 of a row still hold the tail of the previous row, so the
  // col >= 2 condition keeps windows from straddling a row boundary.
  assign w_win_done = w_pix_hs && (r_row >= ROW_CW'(2)) && (r_col >= COL_W'(2));

  conv_line_buffer #(
    .IMG_W (IMG_W),
    .COL_W (COL_W)
  ) u_line_buffer (
    .clk   (clk),
    .i_col (r_col),
    .i_wr  (w_pix_hs),
    .i_pix (bus.pix_data),
    .o_lb1 (w_lb1),
    .o_lb0 (w_lb0)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_st <= ACCEPT;
    else        r_st <= w_st_nxt;
  end

  // Next state: leave ACCEPT on a window-completing pixel, step on mac_ready.
  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_st_nxt = r_st;
    unique case (r_st)
      ACCEPT: if (w_win_done)    w_st_nxt = EMIT0;
      EMIT0:  if (bus.mac_ready) w_st_nxt = EMIT1;
      EMIT1:  if (bus.mac_ready) w_st_nxt = EMIT2;
      EMIT2:  if (bus.mac_ready) w_st_nxt = ACCEPT;
      default:                   w_st_nxt = ACCEPT;
    endcase
  end

  // Outputs: one window row plus the matching kernel row per EMIT state.
  always_comb begin
    bus.pix_ready  = (r_st == ACCEPT);
    bus.mac_valid  = 1'b0;
    bus.data       = '0;
    bus.weight     = '0;
    bus.mac_last   = 1'b0;
    bus.frame_last = 1'b0;
    unique case (r_st)
      EMIT0: begin
        bus.mac_valid = 1'b1;
        bus.data      = r_win[0];
        bus.weight    = r_kernel[k_byte_idx(0, 0) +: ROW_W];
      end
      EMIT1: begin
        bus.mac_valid = 1'b1;
        bus.data      = r_win[1];
        bus.weight    = r_kernel[k_byte_idx(1, 0) +: ROW_W];
      end
      EMIT2: begin
        bus.mac_valid  = 1'b1;
        bus.data       = r_win[2];
        bus.weight     = r_kernel[k_byte_idx(2, 0) +: ROW_W];
        bus.mac_last   = 1'b1;
        bus.frame_last = r_frame_end;
      end
      default: ;
    endcase
  end

  // Raster position of the next incoming pixel; wraps to (0,0) per frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_pix_hs) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + ROW_CW'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  // Window: drop the left column, insert {lb1, lb0, pixel} as the right one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < K; r++) r_win[r] <= '0;
    end else if (w_pix_hs) begin
      r_win[0] <= {w_lb1,        r_win[0][ROW_W-1:PIX_W]};
      r_win[1] <= {w_lb0,        r_win[1][ROW_W-1:PIX_W]};
      r_win[2] <= {bus.pix_data, r_win[2][ROW_W-1:PIX_W]};
    end
  end

  // Kernel loads only while idle, so a window never sees a mixed kernel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        r_kernel <= '0;
    else if (w_load && r_st == ACCEPT) r_kernel <= w_kernel;
  end

  // Remember whether the window being emitted closes the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_frame_end <= 1'b0;
    else if (w_win_done) r_frame_end <= w_row_last && w_col_last;
  end

endmodule

// File: tb/tb_conv_window_feeder.sv
// Scoreboard bench for conv_window_feeder on a 5x4 image.
module tb_conv_window_feeder;
  import conv_pkg::*;

  localparam int IMG_W = 5;
  localparam int IMG_H = 4;
  localparam int FRAME = IMG_W * IMG_H;
  localparam int WPF   = (IMG_W - 2) * (IMG_H - 2);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        w_load = 1'b0;
  logic [71:0] w_kernel = '0;

  conv_window_feeder_if u_if ();

  conv_window_feeder #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .w_load   (w_load),
    .w_kernel (w_kernel),
    .bus      (u_if.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] data;
    logic [23:0] weight;
    logic        last;
    logic        flast;
    int          due;     // cycle beat 0 must first appear, -1 otherwise
  } beat_t;

  beat_t       exp_q [$];
  logic [7:0]  pix_q [$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          win_cnt = 0;
  logic [23:0] last_fl_data = '0;
  bit          gap_en = 1'b0;

  // Reference model state: whole frame kept as a 2-D image.
  logic [7:0]  img [IMG_H][IMG_W];
  int          m_row = 0;
  int          m_col = 0;
  logic [71:0] mk = '0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Pixel source: presents the head of pix_q, pops it after a handshake.
  initial begin : driver
    bit hs;
    u_if.pix_valid = 1'b0;
    u_if.pix_data  = '0;
    forever begin
      @(negedge clk);
      hs = rst_n && u_if.pix_valid && u_if.pix_ready;
      @(posedge clk);
      #1;
      if (hs && pix_q.size() != 0) void'(pix_q.pop_front());
      u_if.pix_valid = (pix_q.size() != 0) && !(gap_en && $urandom_range(0, 3) == 0);
      u_if.pix_data  = (pix_q.size() != 0) ? pix_q[0] : 8'h00;
    end
  end

  // Reference model: on every accepted pixel store it in the image; when it
  // closes a 3x3 window, queue the three expected row-beats.
  initial begin : model
    beat_t e;
    int    r;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_row = 0;
        m_col = 0;
        mk    = '0;
        exp_q.delete();
      end else begin
        if (w_load && u_if.pix_ready) mk = w_kernel;
        if (u_if.pix_valid && u_if.pix_ready) begin
          img[m_row][m_col] = u_if.pix_data;
          if (m_row >= 2 && m_col >= 2) begin
            for (int i = 0; i < 3; i++) begin
              r        = m_row - 2 + i;
              e.data   = {img[r][m_col], img[r][m_col-1], img[r][m_col-2]};
              e.weight = {mk[8*(3*i+2) +: 8], mk[8*(3*i+1) +: 8], mk[8*(3*i) +: 8]};
              e.last   = (i == 2);
              e.flast  = (i == 2) && (m_row == IMG_H - 1) && (m_col == IMG_W - 1);
              e.due    = (i == 0) ? cyc + 1 : -1;
              exp_q.push_back(e);
            end
          end
          m_col++;
          if (m_col == IMG_W) begin
            m_col = 0;
            m_row++;
            if (m_row == IMG_H) m_row = 0;
          end
        end
      end
    end
  end

  // Monitor: compares every presented beat against the scoreboard head.
  initial begin : monitor
    beat_t e;
    bit    fresh;
    fresh = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        fresh = 1'b1;
      end else if (u_if.mac_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {u_if.data, u_if.weight}, 72'd0);
        end else begin
          e = exp_q[0];
          check("beat_data", u_if.data, e.data);
          check("beat_weight", u_if.weight, e.weight);
          check("beat_last", {u_if.mac_last, u_if.frame_last}, {e.last, e.flast});
          if (fresh && e.due >= 0) check("beat0_latency", 72'(cyc), 72'(e.due));
          fresh = 1'b0;
          if (u_if.mac_ready) begin
            void'(exp_q.pop_front());
            fresh = 1'b1;
            if (u_if.mac_last) win_cnt++;
            if (u_if.frame_last) last_fl_data = u_if.data;
          end
        end
      end else begin
        check("idle_outputs_zero",
              {u_if.data, u_if.weight, u_if.mac_last, u_if.frame_last}, 72'd0);
      end
    end
  end

  task automatic wait_valid(input string name);
    int n = 0;
    @(negedge clk);
    while (!u_if.mac_valid && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) check({name, "_timeout"}, 72'd0, 72'd1);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((pix_q.size() != 0 || exp_q.size() != 0 || u_if.mac_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check({name, "_drain_timeout"}, 72'd0, 72'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic load_k(input logic [71:0] k);
    @(posedge clk); #1;
    w_load   = 1'b1;
    w_kernel = k;
    @(posedge clk); #1;
    w_load   = 1'b0;
  endtask

  task automatic push_seq();
    for (int i = 1; i <= FRAME; i++) pix_q.push_back(8'(i));
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++) pix_q.push_back(8'($urandom));
  endtask

  function automatic logic [71:0] rand_k();
    return {8'($urandom), 32'($urandom), 32'($urandom)};
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int          base;
    int          n;
    logic [23:0] d1;
    logic [23:0] wt1;
    logic [71:0] ka;

    u_if.mac_ready = 1'b1;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          {u_if.mac_valid, u_if.mac_last, u_if.frame_last, u_if.data, u_if.weight}, 72'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("pix_ready_after_reset", u_if.pix_ready, 1);
    check("mac_valid_after_reset", u_if.mac_valid, 0);

    // Kernel byte mapping, first window timing, ascending frame
    load_k(72'h090807060504030201);
    base = win_cnt;
    push_seq();
    wait_valid("t1");
    check("t1_b0_data", u_if.data, 24'h030201);
    check("t1_b0_weight", u_if.weight, 24'h030201);
    @(negedge clk);
    check("t1_b1_data", u_if.data, 24'h080706);
    check("t1_b1_weight", u_if.weight, 24'h060504);
    @(negedge clk);
    check("t1_b2_data", u_if.data, 24'h0D0C0B);
    check("t1_b2_weight", u_if.weight, 24'h090807);
    check("t1_b2_last", {u_if.mac_last, u_if.frame_last}, 2'b10);
    @(negedge clk);
    check("t1_pix_ready_t4", u_if.pix_ready, 1);
    drain("t1");
    check("t1_windows", 72'(win_cnt - base), 72'(WPF));
    check("t1_frame_last_data", last_fl_data, 24'h141312);

    // All-ones kernel, two back-to-back frames
    load_k({9{8'h01}});
    base = win_cnt;
    push_seq();
    push_seq();
    wait_valid("t2");
    check("t2_b0_data", u_if.data, 24'h030201);
    check("t2_b0_weight", u_if.weight, 24'h010101);
    drain("t2");
    check("t2_windows", 72'(win_cnt - base), 72'(2 * WPF));
    check("t2_frame_last_data", last_fl_data, 24'h141312);

    // Back-pressure in EMIT1 with an ignored kernel load
    ka = rand_k();
    load_k(ka);
    base = win_cnt;
    push_rand(FRAME);
    wait_valid("t3");
    @(posedge clk); #1;
    u_if.mac_ready = 1'b0;
    w_load   = 1'b1;
    w_kernel = ~ka;
    d1  = '0;
    wt1 = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) begin
        d1  = u_if.data;
        wt1 = u_if.weight;
      end else begin
        check("t3_stall_data", u_if.data, d1);
        check("t3_stall_weight", u_if.weight, wt1);
      end
      check("t3_stall_pix_ready", u_if.pix_ready, 0);
      check("t3_stall_valid_last", {u_if.mac_valid, u_if.mac_last}, 2'b10);
      @(posedge clk); #1;
      w_load = 1'b0;
    end
    u_if.mac_ready = 1'b1;
    @(negedge clk);
    check("t3_release_still_emit1", {u_if.mac_valid, u_if.mac_last}, 2'b10);
    check("t3_release_weight", u_if.weight, ka[47:24]);
    @(negedge clk);
    check("t3_emit2_last", {u_if.mac_valid, u_if.mac_last}, 2'b11);
    check("t3_emit2_weight", u_if.weight, ka[71:48]);
    drain("t3");
    check("t3_windows", 72'(win_cnt - base), 72'(WPF));

    // Random traffic: gaps, random mac_ready, random kernel loads
    gap_en = 1'b1;
    base = win_cnt;
    push_rand(3 * FRAME);
    n = 0;
    while ((pix_q.size() != 0 || exp_q.size() != 0) && n < 3000) begin
      @(posedge clk); #1;
      u_if.mac_ready = ($urandom_range(0, 2) != 0);
      w_load         = ($urandom_range(0, 7) == 0);
      w_kernel       = rand_k();
      n++;
    end
    if (n >= 3000) check("t4_timeout", 72'd0, 72'd1);
    u_if.mac_ready = 1'b1;
    w_load = 1'b0;
    gap_en = 1'b0;
    drain("t4");
    check("t4_windows", 72'(win_cnt - base), 72'(3 * WPF));

    // Reset in the middle of a window
    load_k(rand_k());
    push_rand(FRAME);
    wait_valid("t5");
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t5_reset_outputs",
          {u_if.mac_valid, u_if.mac_last, u_if.frame_last, u_if.data, u_if.weight}, 72'd0);
    pix_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_pix_ready_after_reset", u_if.pix_ready, 1);
    check("t5_mac_valid_after_reset", u_if.mac_valid, 0);
    base = win_cnt;
    push_seq();
    wait_valid("t5b");
    check("t5_b0_data", u_if.data, 24'h030201);
    check("t5_b0_weight_cleared", u_if.weight, 24'h000000);
    drain("t5");
    check("t5_windows", 72'(win_cnt - base), 72'(WPF));
    check("t5_frame_last_data", last_fl_data, 24'h141312);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
